// File: rtl/mxint_dequant_serializer.sv
// MxInt block dequantizer: latches one block (mantissas + shared exponent) and
// streams the elements out one per handshake as saturated signed fixed-point.
module mxint_dequant_serializer #(
    parameter int unsigned MAN_WIDTH  = 8,
    parameter int unsigned EXP_WIDTH  = 4,
    parameter int unsigned BLOCK_SIZE = 4,
    parameter int unsigned OUT_WIDTH  = 16,
    parameter int unsigned FRAC_WIDTH = 4,
    localparam int unsigned IDX_WIDTH = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [MAN_WIDTH-1:0] mdata_in [BLOCK_SIZE-1:0],
    input  logic        [EXP_WIDTH-1:0] edata_in,
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic        [IDX_WIDTH-1:0] data_out_index,
    output logic                        data_out_last,
    output logic                        data_out_sat,
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    localparam int unsigned WIDE_W   = MAN_WIDTH + 2**EXP_WIDTH + FRAC_WIDTH;
    localparam int          EBIAS    = 2**(EXP_WIDTH-1);
    localparam int          SHIFT_OFF = int'(FRAC_WIDTH) - EBIAS;
    localparam logic [IDX_WIDTH-1:0]       LAST_IDX = IDX_WIDTH'(BLOCK_SIZE - 1);
    localparam logic signed [WIDE_W-1:0]   OUT_MAX  = WIDE_W'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [WIDE_W-1:0]   OUT_MIN  = WIDE_W'(-(2**(OUT_WIDTH-1)));

    typedef enum logic {IDLE, SERIAL} state_t;

    state_t                      state_q, state_d;
    logic        [IDX_WIDTH-1:0] idx_q, idx_d;
    logic                        load;
    logic signed [MAN_WIDTH-1:0] man_q [BLOCK_SIZE-1:0];
    logic        [EXP_WIDTH-1:0] exp_q;

    logic signed [WIDE_W-1:0]    wide;
    logic signed [WIDE_W-1:0]    clamped;
    logic                        sat_v;
    logic                        serial;
    logic                        is_last;

    // Shift by the unbiased exponent plus the output fraction; right shifts floor.
    function automatic logic signed [WIDE_W-1:0] dequant(
        input logic signed [MAN_WIDTH-1:0] m,
        input logic        [EXP_WIDTH-1:0] e
    );
        logic signed [WIDE_W-1:0] mw;
        logic signed [31:0]       s;
        mw = WIDE_W'(m);
        s  = $signed(32'(e)) + SHIFT_OFF;
        if (s >= 0) return mw <<< s;
        else        return mw >>> (-s);
    endfunction

    assign serial  = (state_q == SERIAL);
    assign is_last = (idx_q == LAST_IDX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        load           = 1'b0;
        data_in_ready  = 1'b0;
        data_out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                data_in_ready = 1'b1;
                if (data_in_valid) begin
                    load    = 1'b1;
                    idx_d   = '0;
                    state_d = SERIAL;
                end
            end
            SERIAL: begin
                data_out_valid = 1'b1;
                if (data_out_ready) begin
                    if (is_last) begin
                        // Last handshake may accept the next block with no bubble.
                        data_in_ready = 1'b1;
                        idx_d         = '0;
                        if (data_in_valid) load    = 1'b1;
                        else               state_d = IDLE;
                    end else begin
                        idx_d = IDX_WIDTH'(idx_q + IDX_WIDTH'(1));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < int'(BLOCK_SIZE); i++) man_q[i] <= '0;
            exp_q <= '0;
        end else if (load) begin
            for (int i = 0; i < int'(BLOCK_SIZE); i++) man_q[i] <= mdata_in[i];
            exp_q <= edata_in;
        end
    end

    always_comb begin
        wide    = dequant(man_q[idx_q], exp_q);
        clamped = wide;
        sat_v   = 1'b0;
        if (wide > OUT_MAX) begin
            clamped = OUT_MAX;
            sat_v   = 1'b1;
        end else if (wide < OUT_MIN) begin
            clamped = OUT_MIN;
            sat_v   = 1'b1;
        end
    end

    assign data_out       = serial ? OUT_WIDTH'(clamped) : '0;
    assign data_out_index = idx_q;
    assign data_out_last  = serial & is_last;
    assign data_out_sat   = serial & sat_v;

endmodule

// File: tb/tb_mxint_dequant_serializer.sv
// Directed self-checking bench for mxint_dequant_serializer at default parameters.
module tb_mxint_dequant_serializer;

    logic              clk;
    logic              rst;
    logic signed [7:0] mdata_in [3:0];
    logic        [3:0] edata_in;
    logic              data_in_valid;
    logic              data_in_ready;
    logic signed [15:0] data_out;
    logic        [1:0] data_out_index;
    logic              data_out_last;
    logic              data_out_sat;
    logic              data_out_valid;
    logic              data_out_ready;

    int checks = 0;
    int errors = 0;

    int m  [4];
    int ex [4];
    int sx [4];
    int m2 [4];
    int ex2[4];

    mxint_dequant_serializer dut (
        .clk            (clk),
        .rst            (rst),
        .mdata_in       (mdata_in),
        .edata_in       (edata_in),
        .data_in_valid  (data_in_valid),
        .data_in_ready  (data_in_ready),
        .data_out       (data_out),
        .data_out_index (data_out_index),
        .data_out_last  (data_out_last),
        .data_out_sat   (data_out_sat),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_block(input int mm[4], input int e);
        for (int i = 0; i < 4; i++) mdata_in[i] = 8'(mm[i]);
        edata_in = 4'(e);
    endtask

    // One block with ready held high; expectations in ex/sx.
    task automatic run_block(input int e, input string name);
        @(negedge clk);
        drive_block(m, e);
        data_in_valid  = 1'b1;
        data_out_ready = 1'b1;
        #1 check({name, "_in_ready"}, int'(data_in_ready), 1);
        @(negedge clk);
        data_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check($sformatf("%s_valid%0d", name, i), int'(data_out_valid), 1);
            check($sformatf("%s_data%0d", name, i), int'(data_out), ex[i]);
            check($sformatf("%s_idx%0d", name, i), int'(data_out_index), i);
            check($sformatf("%s_last%0d", name, i), int'(data_out_last), (i == 3) ? 1 : 0);
            check($sformatf("%s_sat%0d", name, i), int'(data_out_sat), sx[i]);
            @(negedge clk);
        end
        #1 check({name, "_idle"}, int'(data_out_valid), 0);
    endtask

    initial begin
        int pat [4];
        int exp_i;
        rst            = 1'b0;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b0;
        edata_in       = '0;
        for (int i = 0; i < 4; i++) mdata_in[i] = '0;
        #12;
        check("rst_valid", int'(data_out_valid), 0);
        check("rst_in_ready", int'(data_in_ready), 1);
        check("rst_data", int'(data_out), 0);
        check("rst_idx", int'(data_out_index), 0);
        check("rst_last", int'(data_out_last), 0);
        check("rst_sat", int'(data_out_sat), 0);
        @(negedge clk);
        rst = 1'b1;

        // e=8 -> shift left 4
        m = '{3, -20, 1, 0}; ex = '{48, -320, 16, 0}; sx = '{0, 0, 0, 0};
        run_block(8, "e8");
        // e=0 -> shift right 4 with floor
        ex = '{0, -2, 0, 0};
        run_block(0, "e0");
        // e=15 -> shift left 11, saturating
        m = '{127, -128, 1, -1}; ex = '{32767, -32768, 2048, -2048}; sx = '{1, 1, 0, 0};
        run_block(15, "sat");
        // e=4 -> shift 0, identity
        m = '{-7, 100, -128, 127}; ex = '{-7, 100, -128, 127}; sx = '{0, 0, 0, 0};
        run_block(4, "e4");

        // Back-to-back blocks, no bubble
        m  = '{1, 2, 3, 4};     ex  = '{16, 32, 48, 64};
        m2 = '{-1, -2, -3, -4}; ex2 = '{-32, -64, -96, -128};
        @(negedge clk);
        drive_block(m, 8);
        data_in_valid  = 1'b1;
        data_out_ready = 1'b1;
        @(negedge clk);
        drive_block(m2, 9);
        for (int c = 0; c < 8; c++) begin
            if (c == 4) data_in_valid = 1'b0;
            #1;
            check($sformatf("b2b_valid%0d", c), int'(data_out_valid), 1);
            check($sformatf("b2b_data%0d", c), int'(data_out), (c < 4) ? ex[c] : ex2[c-4]);
            check($sformatf("b2b_idx%0d", c), int'(data_out_index), c % 4);
            if (c < 4)
                check($sformatf("b2b_in_ready%0d", c), int'(data_in_ready), (c == 3) ? 1 : 0);
            @(negedge clk);
        end
        #1 check("b2b_idle", int'(data_out_valid), 0);

        // Backpressure: ready pattern 1,0,0,1
        m = '{5, -6, 7, -8}; ex = '{40, -48, 56, -64};
        pat = '{1, 0, 0, 1};
        @(negedge clk);
        drive_block(m, 7);
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        exp_i = 0;
        for (int c = 0; c < 40 && exp_i < 4; c++) begin
            data_out_ready = pat[c % 4][0];
            #1;
            check($sformatf("bp_valid_c%0d", c), int'(data_out_valid), 1);
            check($sformatf("bp_data_c%0d", c), int'(data_out), ex[exp_i]);
            check($sformatf("bp_idx_c%0d", c), int'(data_out_index), exp_i);
            check($sformatf("bp_in_ready_c%0d", c), int'(data_in_ready),
                  (pat[c % 4] == 1 && exp_i == 3) ? 1 : 0);
            @(negedge clk);
            if (pat[c % 4] == 1) exp_i++;
        end
        check("bp_done", exp_i, 4);
        data_out_ready = 1'b1;
        #1 check("bp_idle", int'(data_out_valid), 0);

        // Reset mid-block after element 1 handshakes
        m = '{9, 10, 11, 12};
        @(negedge clk);
        drive_block(m, 8);
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
        #1 check("mid_data0", int'(data_out), 144);
        @(negedge clk);
        #1 check("mid_data1", int'(data_out), 160);
        @(negedge clk);
        #1 check("mid_idx2", int'(data_out_index), 2);
        rst = 1'b0;
        #1;
        check("mid_rst_valid", int'(data_out_valid), 0);
        check("mid_rst_data", int'(data_out), 0);
        check("mid_rst_idx", int'(data_out_index), 0);
        check("mid_rst_in_ready", int'(data_in_ready), 1);
        @(negedge clk);
        rst = 1'b1;
        m = '{2, -3, 4, -5}; ex = '{8, -12, 16, -20}; sx = '{0, 0, 0, 0};
        run_block(6, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mxint_dequant_serializer.md
Name: mxint_dequant_serializer

Overview:
- Downstream consumer of the MxInt cast stage.
- Accepts one MxInt block per handshake: BLOCK_SIZE signed mantissas plus one shared biased exponent.
- Dequantizes each element to signed fixed-point and emits the elements serially, one per output handshake, with element index and last flag.
- Feeds scalar fixed-point datapaths (activation, accumulation, debug taps) that cannot consume a full block in parallel.

Parameters:
- MAN_WIDTH, 8, signed mantissa width of input elements.
- EXP_WIDTH, 4, unsigned biased shared exponent width; EBIAS = 2**(EXP_WIDTH-1).
- BLOCK_SIZE, 4, mantissas per block (>=1).
- OUT_WIDTH, 16, signed fixed-point output width.
- FRAC_WIDTH, 4, fractional bits of output fixed-point format.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- mdata_in  in  MAN_WIDTH x [BLOCK_SIZE-1:0] unpacked  signed mantissas
- edata_in  in  EXP_WIDTH  shared biased exponent (unsigned)
- data_in_valid  in  1  block valid
- data_in_ready  out  1  block accepted when valid&ready
- data_out  out  OUT_WIDTH  dequantized element, signed fixed-point
- data_out_index  out  max(1,$clog2(BLOCK_SIZE))  element position in block
- data_out_last  out  1  high on element BLOCK_SIZE-1
- data_out_sat  out  1  high when current data_out was saturated
- data_out_valid  out  1  element valid
- data_out_ready  in  1  downstream accept

Behaviour:
- Reset (rst low, async assert, sync deassert):
  - state=IDLE, index=0, holding registers cleared.
  - data_out_valid=0, data_in_ready=1, data_out=0, data_out_index=0, data_out_last=0, data_out_sat=0.
- States:
  - IDLE: data_in_ready=1, data_out_valid=0. On in-handshake, latch all mantissas and exponent, index=0 -> SERIAL.
  - SERIAL: data_out_valid=1; outputs derived combinationally from holding regs[index].
    - Out-handshake with index<BLOCK_SIZE-1: index+1.
    - Out-handshake on last element: if data_in_valid in same cycle, latch new block, index=0, stay SERIAL (no bubble); else -> IDLE.
- data_in_ready = (state==IDLE) | (state==SERIAL & index==BLOCK_SIZE-1 & data_out_ready). Combinational path from data_out_ready to data_in_ready is intentional.
- Latency: first element valid the cycle after input handshake.
- Throughput: one element per cycle under continuous ready; BLOCK_SIZE cycles per block.
- Output stability: data_out, index, last and sat are held stable while valid & !ready.
- Arithmetic:
  - s = edata - EBIAS + FRAC_WIDTH, signed, evaluated at sufficient width (no overflow).
  - s >= 0: wide = mant << s, sign-extended, width MAN_WIDTH + 2**EXP_WIDTH + FRAC_WIDTH.
  - s < 0: wide = mant >>> (-s), arithmetic floor. Shift >= MAN_WIDTH yields 0 or -1 by sign.
  - Saturate to [-2**(OUT_WIDTH-1), 2**(OUT_WIDTH-1)-1]; data_out_sat=1 iff clamping occurred.
- BLOCK_SIZE==1: every element has last=1 and index=0; back-to-back blocks stream at one per cycle.
- Reset asserted mid-block: block discarded, outputs return to reset values immediately (async).
- data_in_valid while SERIAL and not on a last handshake: ignored, ready=0, input must be held by upstream.

Test Plan:
- Defaults (EBIAS=8, FRAC=4). Block {3,-20,1,0}, e=8, data_out_ready=1:
  - Expect outputs 48, -320, 16, 0 on cycles 1-4.
  - index 0..3; last only on 4th; sat=0.
- Same mantissas, e=0 (s=-4):
  - Expect 0, -2, 0, 0 (floor: -20>>>4=-2, 3>>>4=0).
- Saturation, e=15 (s=11), block {127,-128,1,-1}:
  - Expect 32767 (sat=1), -32768 (sat=1), 2048 (sat=0), -2048 (sat=0).
- Back-to-back: two blocks presented continuously, ready=1:
  - Expect 8 consecutive valid cycles with no bubble.
  - Second block accepted in same cycle as first block's last handshake.
- Backpressure: data_out_ready toggles 1,0,0,1 per cycle:
  - data_out is held stable during stalls; no element lost or duplicated.
  - data_in_ready stays 0 until last-element handshake.
- Reset: assert rst low after element index 1 is emitted:
  - valid drops to 0 asynchronously.
  - After release, next block starts at index 0 with its own values.
